// File: rtl/cgra_sram_stream_master.sv
// Burst initiator for one CGRA single-port SRAM bank: turns (op, addr, len) commands into
// per-word requests, streaming write data in and read data out through a 2-entry credit buffer.
module cgra_sram_stream_master #(
    parameter int NumWords  = 1024,
    parameter int AddrWidth = (NumWords <= 1) ? 1 : $clog2(NumWords),
    parameter int BufDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [AddrWidth:0]   cmd_len_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [31:0]          wr_data_i,
    input  logic [3:0]           wr_be_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [31:0]          rd_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic [3:0]           be_o,
    output logic                 set_retentive_no,
    input  logic [31:0]          rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth:0]   r_remaining;
    logic                 r_inflight;
    logic [31:0]          r_buf [2];
    logic                 r_wrPtr;
    logic                 r_rdPtr;
    logic [1:0]           r_count;

    logic                 w_wrFire;
    logic                 w_rdReq;
    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_used;
    logic [AddrWidth-1:0] w_addrNext;

    assign w_wrFire = (r_state == S_WRITE) && wr_valid_i;
    assign w_push   = r_inflight;
    assign w_pop    = (r_count != 2'd0) && rd_ready_i;

    // A word leaving the buffer this cycle frees its slot immediately, so back-to-back
    // reads sustain one word per cycle with only two entries.
    assign w_used  = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rdReq = (r_state == S_READ) && (r_remaining != '0) && (w_used < 3'(BufDepth));

    assign w_addrNext = (r_addr == AddrWidth'(NumWords - 1)) ? '0 : r_addr + 1'b1;

    assign req_o            = w_wrFire | w_rdReq;
    assign we_o             = w_wrFire;
    assign wr_ready_o       = w_wrFire;
    assign addr_o           = r_addr;
    assign wdata_o          = (r_state == S_WRITE) ? wr_data_i : 32'h0;
    assign be_o             = (r_state == S_WRITE) ? wr_be_i : 4'h0;
    assign cmd_ready_o      = (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign done_o           = (r_state == S_DONE);
    assign rd_valid_o       = (r_count != 2'd0);
    assign rd_data_o        = r_buf[r_rdPtr];
    assign set_retentive_no = 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_addr      <= cmd_addr_i;
                        r_remaining <= cmd_len_i;
                        if (cmd_len_i == '0)
                            r_state <= S_DONE;
                        else if (cmd_write_i)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_wrFire) begin
                        r_addr      <= w_addrNext;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (AddrWidth + 1)'(1))
                            r_state <= S_DONE;
                    end
                end
                S_READ: begin
                    if (w_rdReq) begin
                        r_addr      <= w_addrNext;
                        r_remaining <= r_remaining - 1'b1;
                    end
                    if ((r_remaining == '0) && !r_inflight && (r_count == 2'd0))
                        r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data returns one cycle after its request and is always captured; the credit
    // check above guarantees a free slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_rdReq;
            if (w_push) begin
                r_buf[r_wrPtr] <= rdata_i;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop)
                r_rdPtr <= ~r_rdPtr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_sram_stream_master.sv
// Self-checking bench: directed bursts plus random ones, compared against a word-level
// memory model and expected-address/data sequences derived from the burst commands.
module tb_cgra_sram_stream_master;

    localparam int N  = 1024;
    localparam int AW = 10;

    logic          clk_i;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [AW:0]   cmd_len_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [31:0]   wr_data_i;
    logic [3:0]    wr_be_i;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [31:0]   rd_data_o;
    logic          busy_o;
    logic          done_o;
    logic          req_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic [3:0]    be_o;
    logic          set_retentive_no;
    logic [31:0]   rdata_i;

    logic [31:0]   bankMem [N];
    logic [31:0]   refMem [N];
    logic          initMem;
    int            checks;
    int            passes;

    cgra_sram_stream_master #(.NumWords(N)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_write_i      (cmd_write_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_len_i        (cmd_len_i),
        .wr_valid_i       (wr_valid_i),
        .wr_ready_o       (wr_ready_o),
        .wr_data_i        (wr_data_i),
        .wr_be_i          (wr_be_i),
        .rd_valid_o       (rd_valid_o),
        .rd_ready_i       (rd_ready_i),
        .rd_data_o        (rd_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .req_o            (req_o),
        .we_o             (we_o),
        .addr_o           (addr_o),
        .wdata_o          (wdata_o),
        .be_o             (be_o),
        .set_retentive_no (set_retentive_no),
        .rdata_i          (rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single-port bank with one-cycle read latency; preloaded with addr<<8.
    always @(posedge clk_i) begin
        if (initMem) begin
            for (int i = 0; i < N; i++) bankMem[i] <= 32'(i) << 8;
        end else if (req_o) begin
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (be_o[b]) bankMem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
            end else begin
                rdata_i <= bankMem[addr_o];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            passes++;
    endtask

    task automatic applyStimulus(input logic isWrite, input int addr, input int len);
        cmd_valid_i = 1'b1;
        cmd_write_i = isWrite;
        cmd_addr_i  = AW'(addr);
        cmd_len_i   = (AW + 1)'(len);
        #1;
        checkOutput("cmd_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic checkDoneCycle(input string tag);
        #1;
        checkOutput({tag, "_done"}, done_o, 1);
        checkOutput({tag, "_busy_done"}, busy_o, 1);
        checkOutput({tag, "_cmdrdy_done"}, cmd_ready_o, 0);
        checkOutput({tag, "_req_done"}, req_o, 0);
        @(negedge clk_i);
        #1;
        checkOutput({tag, "_done_clr"}, done_o, 0);
        checkOutput({tag, "_busy_idle"}, busy_o, 0);
        checkOutput({tag, "_cmdrdy_idle"}, cmd_ready_o, 1);
    endtask

    // mode 0: valid always, data 0xA0+i, be 0xF; mode 1: valid toggles, be 0x3; mode 2: random
    task automatic writeBurst(input int addr, input int len, input int mode);
        int idx = 0;
        int miss = 0;
        int cyc = 0;
        logic v;
        logic [31:0] d;
        logic [3:0] be;
        applyStimulus(1'b1, addr, len);
        while (idx < len && cyc < 30 * len + 40) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else v = ($urandom_range(0, 2) != 0) || (miss >= 3);
            d  = (mode == 0) ? 32'hA0 + 32'(idx) : $urandom;
            be = (mode == 0) ? 4'hF : (mode == 1) ? 4'h3 : 4'($urandom_range(0, 15));
            wr_valid_i = v;
            wr_data_i  = d;
            wr_be_i    = be;
            #1;
            checkOutput("wr_done_early", done_o, 0);
            if (v) begin
                checkOutput("wr_req", req_o, 1);
                checkOutput("wr_we", we_o, 1);
                checkOutput("wr_ready", wr_ready_o, 1);
                checkOutput("wr_addr", addr_o, 32'((addr + idx) % N));
                checkOutput("wr_wdata", wdata_o, d);
                checkOutput("wr_be", be_o, be);
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[(addr + idx) % N][8*b +: 8] = d[8*b +: 8];
                idx++;
                miss = 0;
            end else begin
                checkOutput("wr_stall_req", req_o, 0);
                checkOutput("wr_stall_ready", wr_ready_o, 0);
                miss++;
            end
            @(negedge clk_i);
            cyc++;
        end
        wr_valid_i = 1'b0;
        checkOutput("wr_count", idx, len);
        checkDoneCycle("wr");
    endtask

    // mode 0: ready always; mode 1: ready low for 'stall' cycles then high; mode 2: random
    task automatic readBurst(input int addr, input int len, input int mode, input int stall);
        logic [31:0] expQ [$];
        int popIdx = 0;
        int reqIdx = 0;
        int stallReqs = 0;
        int cyc = 0;
        int firstValid = -1;
        logic rdy;
        logic prevHold = 1'b0;
        logic [31:0] prevData = '0;
        for (int i = 0; i < len; i++) expQ.push_back(refMem[(addr + i) % N]);
        applyStimulus(1'b0, addr, len);
        while (popIdx < len && cyc < 30 * len + 40) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc >= stall);
            else rdy = 1'($urandom_range(0, 1));
            rd_ready_i = rdy;
            #1;
            checkOutput("rd_done_early", done_o, 0);
            if (req_o) begin
                checkOutput("rd_we", we_o, 0);
                checkOutput("rd_be", be_o, 0);
                checkOutput("rd_addr", addr_o, 32'((addr + reqIdx) % N));
                reqIdx++;
                if (cyc < stall) stallReqs++;
            end
            if (rd_valid_o && firstValid < 0) firstValid = cyc;
            if (prevHold) begin
                checkOutput("rd_hold_valid", rd_valid_o, 1);
                checkOutput("rd_hold_data", rd_data_o, prevData);
            end
            if (rd_valid_o && rdy) begin
                checkOutput("rd_data", rd_data_o, expQ[popIdx]);
                popIdx++;
            end
            prevHold = rd_valid_o && !rdy;
            prevData = rd_data_o;
            @(negedge clk_i);
            cyc++;
        end
        rd_ready_i = 1'b1;
        checkOutput("rd_count", popIdx, len);
        checkOutput("rd_reqs", reqIdx, len);
        if (len > 0) checkOutput("rd_latency", firstValid, 2);
        if (stall > 2) checkOutput("rd_stall_reqs", stallReqs, (len < 2) ? len : 2);
        for (int w = 0; w < 4; w++) begin
            #1;
            if (done_o) break;
            @(negedge clk_i);
        end
        checkOutput("rd_valid_at_done", rd_valid_o, 0);
        checkDoneCycle("rd");
    endtask

    initial begin
        int lastWr;
        checks      = 0;
        passes      = 0;
        initMem     = 1'b1;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        wr_valid_i  = 1'b0;
        wr_data_i   = '0;
        wr_be_i     = '0;
        rd_ready_i  = 1'b1;
        for (int i = 0; i < N; i++) refMem[i] = 32'(i) << 8;
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_rd_valid", rd_valid_o, 0);
        checkOutput("rst_req", req_o, 0);
        checkOutput("rst_we", we_o, 0);
        checkOutput("rst_addr", addr_o, 0);
        checkOutput("rst_be", be_o, 0);
        checkOutput("rst_wdata", wdata_o, 0);
        checkOutput("rst_retentive", set_retentive_no, 1);
        initMem = 1'b0;
        rst_i   = 1'b0;
        @(negedge clk_i);

        $display("[TB] directed bursts");
        readBurst(32'h010, 3, 0, 0);
        writeBurst(32'h3FE, 4, 0);
        readBurst(32'h3FE, 4, 0, 0);
        readBurst(32'h100, 5, 1, 10);
        writeBurst(32'h040, 3, 1);
        readBurst(32'h040, 3, 2, 0);
        writeBurst(32'h005, 0, 0);
        readBurst(32'h007, 0, 0, 0);

        $display("[TB] reset during read burst");
        applyStimulus(1'b0, 32'h020, 5);
        rd_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("pre_rst_valid", rd_valid_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_valid", rd_valid_o, 0);
        checkOutput("mid_rst_req", req_o, 0);
        checkOutput("mid_rst_done", done_o, 0);
        checkOutput("mid_rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i      = 1'b0;
        rd_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            #1;
            checkOutput("post_rst_done", done_o, 0);
            checkOutput("post_rst_valid", rd_valid_o, 0);
        end
        @(negedge clk_i);
        readBurst(32'h030, 4, 0, 0);

        $display("[TB] random bursts");
        lastWr = 0;
        for (int k = 0; k < 12; k++) begin
            int a;
            int l;
            a = $urandom_range(0, N - 1);
            l = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                writeBurst(a, l, 2);
                lastWr = a;
            end else begin
                readBurst(($urandom_range(0, 1) == 1) ? lastWr : a, l, 2, 0);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cgra_sram_stream_master.md
Name: cgra_sram_stream_master

Overview:
- Initiator for the CGRA single-port SRAM bank interface (req/we/addr/wdata/be, 1-cycle read latency).
- Turns a burst command (op, start address, length) into per-word SRAM requests.
- Write data arrives on a valid/ready stream. Read data leaves on a valid/ready stream through a 2-entry credit-controlled buffer.
- Sits between the CGRA context/data loader and one bank wrapper instance.

Parameters:
NumWords, 1024, words in target bank; addresses wrap modulo NumWords
AddrWidth, $clog2(NumWords) (1 if NumWords<=1), derived, do not override
BufDepth, 2, read-return buffer entries; fixed at 2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1=write burst, 0=read burst
cmd_addr_i  in  AddrWidth  start word address
cmd_len_i  in  AddrWidth+1  burst length in words (0 legal)
wr_valid_i  in  1  write word valid
wr_ready_o  out  1  write word consumed
wr_data_i  in  32  write word
wr_be_i  in  4  write byte enables
rd_valid_o  out  1  read word valid
rd_ready_i  in  1  read word consumed
rd_data_o  out  32  read word
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at burst completion
req_o  out  1  SRAM request
we_o  out  1  SRAM write enable
addr_o  out  AddrWidth  SRAM word address
wdata_o  out  32  SRAM write data
be_o  out  4  SRAM byte enables
set_retentive_no  out  1  tied 1
rdata_i  in  32  SRAM read data, valid the cycle after a read req

Behaviour:
- Reset, asynchronous:
  - Outputs: cmd_ready_o=1, busy_o=0, done_o=0, rd_valid_o=0, req_o=0, we_o=0, addr_o=0, be_o=0, wdata_o=0.
  - State: state=IDLE, buffer empty, inflight=0.
  - Reset mid-burst aborts silently: no done_o, pending and buffered data discarded.
- State IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch addr and remaining=cmd_len_i.
  - len=0: go to DONE.
  - Otherwise go to WRITE or READ per cmd_write_i.
  - First SRAM request possible in the cycle after acceptance.
- State WRITE:
  - req_o=we_o=wr_ready_o=wr_valid_i (combinational pass-through).
  - wdata_o=wr_data_i, be_o=wr_be_i, addr_o=current addr.
  - On each handshake: addr+=1 (wrap NumWords-1 -> 0), remaining-=1.
  - After the last handshake go to DONE.
  - Stalls on wr_valid_i=0 indefinitely, issuing no requests.
- State READ:
  - req_o=1, we_o=0, be_o=0 when remaining>0 and (buffer count + inflight) < BufDepth.
  - inflight is set the cycle after a read req.
  - rdata_i is captured into the buffer on that cycle, unconditionally; space is guaranteed by credit.
  - Buffer is FIFO-ordered.
  - rd_valid_o = buffer not empty; rd_data_o = head entry.
  - Pop on rd_valid_o & rd_ready_i.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - With rd_ready_i held 1: one word per cycle after a 2-cycle initial latency (req at cycle t, rd_valid_o at t+2 through registered buffer).
  - Go to DONE when remaining=0, inflight=0 and buffer empty (last word popped).
- State DONE: done_o=1 for exactly one cycle, cmd_ready_o=0, then IDLE.
- cmd_ready_o=0 in all states except IDLE. No new command is accepted in the done cycle.
- Addresses wrap modulo NumWords. A burst with len > NumWords re-visits addresses, which is legal.
- rd_valid_o/rd_data_o are held stable while rd_ready_i=0.
- wr_ready_o=0 outside WRITE.

Test Plan:
- Write burst addr=0x3FE, len=4, data 0xA0..0xA3, be=0xF, wr_valid_i always 1 -> req_o&we_o on 4 consecutive cycles at addr 0x3FE,0x3FF,0x000,0x001; done_o one cycle after last; busy_o falls with it.
- Read burst addr=0x010, len=3, bank model returns addr<<8, rd_ready_i=1 -> rd_data_o=0x1000,0x1100,0x1200 in order, first at cmd accept+3 cycles; done_o after last pop.
- Read len=5 with rd_ready_i=0 for 10 cycles, then 1 -> exactly 2 req_o issued during the stall; rd_data_o stable; all 5 words then delivered in order with no loss.
- Write len=3 with wr_valid_i toggling 1,0,1,0,1 -> exactly 3 SRAM writes, only on valid cycles, addresses consecutive, be_o follows wr_be_i (e.g. 0x3).
- Command len=0 -> no req_o, done_o pulses the cycle after acceptance, back to IDLE.
- Assert rst_i mid read burst with 2 buffered words -> rd_valid_o=0, req_o=0 immediately, no done_o; next read command starts cleanly from its own address.
